// File: rtl/tm1640_pkg.sv
// Shared types and constants for the TM1640 serial transmitter.
package tm1640_pkg;

    localparam int unsigned GRID_MAX                 = 16;
    localparam int unsigned TICKS_PER_FRAME_OVERHEAD = 4;
    localparam int unsigned TICKS_PER_BYTE           = 16;

    localparam logic [7:0] CMD_DATA_AUTOINC = 8'h40;
    localparam logic [7:0] CMD_ADDR0        = 8'hC0;
    localparam logic [7:0] CMD_DISP_DEFAULT = 8'h8A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BIT_LO,
        ST_BIT_HI,
        ST_STOP_A,
        ST_STOP_B,
        ST_STOP_C,
        ST_FIN
    } state_t;

    // Ticks for the three-frame sequence carrying n data bytes in frame 1.
    function automatic int unsigned seq_ticks(input int unsigned n);
        return 3 * (TICKS_PER_FRAME_OVERHEAD + TICKS_PER_BYTE) + TICKS_PER_BYTE * n;
    endfunction

endpackage

// File: rtl/tm1640_serial_tx_if.sv
// Upstream byte stream, command inputs and TM1640 line outputs.
interface tm1640_serial_tx_if;
    logic       tvalid;
    logic [7:0] tdata;
    logic [7:0] send_bytes;
    logic [7:0] cmd1;
    logic [7:0] cmd2;
    logic [7:0] cmd3;
    logic       busy;
    logic       done;
    logic       overflow;
    logic       drop;
    logic       scl;
    logic       sda;

    modport master (
        output tvalid, tdata, send_bytes, cmd1, cmd2, cmd3,
        input  busy, done, overflow, drop, scl, sda
    );

    modport slave (
        input  tvalid, tdata, send_bytes, cmd1, cmd2, cmd3,
        output busy, done, overflow, drop, scl, sda
    );
endinterface

// File: rtl/tm1640_tick_gen.sv
// Half-bit-period divider: one-cycle tick every CLK_DIV cycles while enabled.
module tm1640_tick_gen #(
    parameter int unsigned CLK_DIV = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic tick_c
);
    localparam int unsigned CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart || !en) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign tick_c = en && !restart && (cnt_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tm1640_serial_tx.sv
// TM1640 protocol engine: buffers a column-byte burst, then sends the
// cmd1 / cmd2+data / cmd3 frames LSB-first on scl/sda and pulses done.
import tm1640_pkg::*;

module tm1640_serial_tx #(
    parameter int unsigned CLK_DIV = 50,
    parameter int unsigned DEPTH   = GRID_MAX
) (
    input logic                clk,
    input logic                rst,
    tm1640_serial_tx_if.slave  bus
);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t            state_q, state_d;
    logic [1:0]        frame_q, frame_d;
    logic [CNT_W-1:0]  byte_q,  byte_d;
    logic [2:0]        bit_q,   bit_d;

    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]  n_q,      n_d;
    logic [7:0]        cmd1_q, cmd1_d;
    logic [7:0]        cmd2_q, cmd2_d;
    logic [7:0]        cmd3_q, cmd3_d;
    logic              overflow_q, overflow_d;
    logic              drop_q,     drop_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic              scl_q,      scl_d;
    logic              sda_q,      sda_d;

    logic [7:0]        buf_q [DEPTH];

    logic              launch_c;
    logic              wr_en_c;
    logic              tick_c;
    logic [CNT_W-1:0]  last_byte_c;
    logic [CNT_W-1:0]  data_idx_c;
    logic [7:0]        cur_byte_c;

    tm1640_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .en      (busy_q),
        .restart (launch_c),
        .tick_c  (tick_c)
    );

    assign launch_c    = !busy_q && !bus.tvalid && (wr_cnt_q != '0);
    assign wr_en_c     = !busy_q && bus.tvalid && (32'(wr_cnt_q) < DEPTH);
    assign last_byte_c = (frame_q == 2'd1) ? n_q : '0;

    // Capture buffer, overflow/drop flags and launch-time command sampling.
    always_comb begin
        wr_cnt_d   = wr_cnt_q;
        overflow_d = overflow_q;
        drop_d     = bus.tvalid && busy_q;
        n_d        = n_q;
        cmd1_d     = cmd1_q;
        cmd2_d     = cmd2_q;
        cmd3_d     = cmd3_q;
        if (state_q == ST_FIN) begin
            wr_cnt_d   = '0;
            overflow_d = 1'b0;
        end else if (wr_en_c) begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end else if (!busy_q && bus.tvalid) begin
            overflow_d = 1'b1;
        end
        if (launch_c) begin
            cmd1_d = bus.cmd1;
            cmd2_d = bus.cmd2;
            cmd3_d = bus.cmd3;
            n_d    = (32'(bus.send_bytes) > DEPTH) ? CNT_W'(DEPTH) : CNT_W'(bus.send_bytes);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            buf_q[ADDR_W'(wr_cnt_q)] <= bus.tdata;
        end
    end

    // Next state: every state except FIN holds for exactly one tick.
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        byte_d  = byte_q;
        bit_d   = bit_q;
        case (state_q)
            ST_IDLE: begin
                if (launch_c) begin
                    state_d = ST_START;
                    frame_d = 2'd0;
                    byte_d  = '0;
                    bit_d   = 3'd0;
                end
            end
            ST_START:  if (tick_c) state_d = ST_BIT_LO;
            ST_BIT_LO: if (tick_c) state_d = ST_BIT_HI;
            ST_BIT_HI: begin
                if (tick_c) begin
                    if (bit_q != 3'd7) begin
                        bit_d   = bit_q + 3'd1;
                        state_d = ST_BIT_LO;
                    end else if (byte_q != last_byte_c) begin
                        byte_d  = byte_q + CNT_W'(1);
                        bit_d   = 3'd0;
                        state_d = ST_BIT_LO;
                    end else begin
                        state_d = ST_STOP_A;
                    end
                end
            end
            ST_STOP_A: if (tick_c) state_d = ST_STOP_B;
            ST_STOP_B: if (tick_c) state_d = ST_STOP_C;
            ST_STOP_C: begin
                if (tick_c) begin
                    if (frame_q != 2'd2) begin
                        frame_d = frame_q + 2'd1;
                        byte_d  = '0;
                        bit_d   = 3'd0;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Byte on the wire for the upcoming position; unfilled slots pad with zero.
    always_comb begin
        data_idx_c = byte_d - CNT_W'(1);
        cur_byte_c = 8'h00;
        case (frame_d)
            2'd0: cur_byte_c = cmd1_q;
            2'd1: begin
                if (byte_d == '0) begin
                    cur_byte_c = cmd2_q;
                end else if (data_idx_c < wr_cnt_q) begin
                    cur_byte_c = buf_q[ADDR_W'(data_idx_c)];
                end
            end
            default: cur_byte_c = cmd3_q;
        endcase
    end

    always_comb begin
        scl_d  = 1'b1;
        sda_d  = sda_q;
        busy_d = busy_q;
        done_d = (state_q == ST_FIN);
        case (state_d)
            ST_IDLE:   sda_d = 1'b1;
            ST_START:  sda_d = 1'b0;
            ST_BIT_LO: begin
                scl_d = 1'b0;
                sda_d = cur_byte_c[bit_d];
            end
            ST_BIT_HI: sda_d = sda_q;
            ST_STOP_A: begin
                scl_d = 1'b0;
                sda_d = 1'b0;
            end
            ST_STOP_B: sda_d = 1'b0;
            ST_STOP_C: sda_d = 1'b1;
            ST_FIN:    sda_d = 1'b1;
            default:   sda_d = 1'b1;
        endcase
        if (launch_c) begin
            busy_d = 1'b1;
        end else if (state_q == ST_FIN) begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q    <= 2'd0;
            byte_q     <= '0;
            bit_q      <= 3'd0;
            wr_cnt_q   <= '0;
            n_q        <= '0;
            cmd1_q     <= 8'h00;
            cmd2_q     <= 8'h00;
            cmd3_q     <= 8'h00;
            overflow_q <= 1'b0;
            drop_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            scl_q      <= 1'b1;
            sda_q      <= 1'b1;
        end else begin
            frame_q    <= frame_d;
            byte_q     <= byte_d;
            bit_q      <= bit_d;
            wr_cnt_q   <= wr_cnt_d;
            n_q        <= n_d;
            cmd1_q     <= cmd1_d;
            cmd2_q     <= cmd2_d;
            cmd3_q     <= cmd3_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            scl_q      <= scl_d;
            sda_q      <= sda_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.overflow = overflow_q;
    assign bus.drop     = drop_q;
    assign bus.scl      = scl_q;
    assign bus.sda      = sda_q;

endmodule

// File: tb/tb_tm1640_serial_tx.sv
// Scoreboard bench: stimulus queues expected frames, a line monitor decodes scl/sda.
module tb_tm1640_serial_tx;
    import tm1640_pkg::*;

    localparam int unsigned CLK_DIV = 2;
    localparam int unsigned DEPTH   = 16;
    localparam int          LIMIT   = 4000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tm1640_serial_tx_if bus_if ();

    tm1640_serial_tx #(.CLK_DIV(CLK_DIV), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_bytes[$];
    int         exp_flen[$];

    int   done_seen   = 0;
    int   drop_seen   = 0;
    int   glitch_cnt  = 0;
    int   frames_seen = 0;
    bit   in_frame    = 1'b0;
    logic bitq[$];
    logic scl_p = 1'b1;
    logic sda_p = 1'b1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Line monitor: start/stop detection, bit capture on scl rise, frame check at stop.
    always @(negedge clk) begin
        if (rst) begin
            in_frame = 1'b0;
            bitq.delete();
            scl_p = 1'b1;
            sda_p = 1'b1;
        end else begin
            if (bus_if.done) done_seen++;
            if (bus_if.drop) drop_seen++;
            if (scl_p && bus_if.scl && sda_p && !bus_if.sda) begin
                in_frame = 1'b1;
                bitq.delete();
            end else if (scl_p && bus_if.scl && !sda_p && bus_if.sda) begin
                if (in_frame) begin
                    int nbits;
                    int got;
                    int want;
                    // the last scl rise belongs to the stop sequence, not to data
                    nbits = bitq.size() - 1;
                    got   = nbits / 8;
                    check("frame_bit_align", nbits % 8, 0);
                    if (exp_flen.size() == 0) begin
                        fail("frame_unexpected");
                    end else begin
                        want = exp_flen.pop_front();
                        check("frame_len", got, want);
                        for (int b = 0; b < want; b++) begin
                            logic [7:0] v;
                            logic [7:0] e;
                            v = 8'h00;
                            for (int k = 0; k < 8; k++) begin
                                if (b * 8 + k < nbits) v[k] = bitq[b * 8 + k];
                            end
                            e = (exp_bytes.size() > 0) ? exp_bytes.pop_front() : 8'hxx;
                            check($sformatf("frame%0d_byte%0d", frames_seen % 3, b), int'(v), int'(e));
                        end
                    end
                    frames_seen++;
                end
                in_frame = 1'b0;
            end else if (!scl_p && bus_if.scl && in_frame) begin
                if (sda_p != bus_if.sda) glitch_cnt++;
                bitq.push_back(bus_if.sda);
            end
            scl_p = bus_if.scl;
            sda_p = bus_if.sda;
        end
    end

    task automatic push_expected(input logic [7:0] data[$], input int sb,
                                 input logic [7:0] c1, input logic [7:0] c2, input logic [7:0] c3);
        int cap;
        int n;
        cap = (data.size() < DEPTH) ? data.size() : DEPTH;
        n   = (sb < DEPTH) ? sb : DEPTH;
        exp_bytes.push_back(c1);
        exp_flen.push_back(1);
        exp_bytes.push_back(c2);
        for (int i = 0; i < n; i++) exp_bytes.push_back((i < cap) ? data[i] : 8'h00);
        exp_flen.push_back(1 + n);
        exp_bytes.push_back(c3);
        exp_flen.push_back(1);
    endtask

    task automatic load_burst(input logic [7:0] data[$], input int sb,
                              input logic [7:0] c1, input logic [7:0] c2, input logic [7:0] c3);
        @(posedge clk); #1;
        bus_if.send_bytes = 8'(sb);
        bus_if.cmd1 = c1;
        bus_if.cmd2 = c2;
        bus_if.cmd3 = c3;
        push_expected(data, sb, c1, c2, c3);
        foreach (data[i]) begin
            bus_if.tvalid = 1'b1;
            bus_if.tdata  = data[i];
            @(posedge clk); #1;
            check($sformatf("overflow_byte%0d", i + 1), int'(bus_if.overflow), (i >= DEPTH) ? 1 : 0);
        end
        bus_if.tvalid = 1'b0;
        bus_if.tdata  = 8'($urandom);
        @(posedge clk); #1;
        check("busy_after_launch", int'(bus_if.busy), 1);
        check("overflow_held", int'(bus_if.overflow), (data.size() > DEPTH) ? 1 : 0);
        // inputs change after launch must not affect the transfer
        bus_if.send_bytes = 8'($urandom);
        bus_if.cmd1 = 8'($urandom);
        bus_if.cmd2 = 8'($urandom);
        bus_if.cmd3 = 8'($urandom);
    endtask

    task automatic run_burst(input logic [7:0] data[$], input int sb,
                             input logic [7:0] c1, input logic [7:0] c2, input logic [7:0] c3,
                             input int drop_at);
        int busy_len;
        int cyc;
        int d0;
        int dn0;
        int n;
        int nom;
        n   = (sb < DEPTH) ? sb : DEPTH;
        nom = (60 + 16 * n) * CLK_DIV;
        dn0 = done_seen;
        d0  = drop_seen;
        load_burst(data, sb, c1, c2, c3);
        busy_len = 1;
        cyc = 0;
        while (!bus_if.done && cyc < LIMIT) begin
            if (drop_at > 0 && cyc >= drop_at && cyc < drop_at + 3) begin
                bus_if.tvalid = 1'b1;
                bus_if.tdata  = 8'($urandom);
            end else begin
                bus_if.tvalid = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
            if (bus_if.busy) busy_len++;
        end
        bus_if.tvalid = 1'b0;
        if (!bus_if.done) begin
            fail("done_timeout");
        end else begin
            check("busy_at_done", int'(bus_if.busy), 0);
            check("overflow_at_done", int'(bus_if.overflow), 0);
            check("busy_len_window", int'(busy_len >= nom - 2 && busy_len <= nom + 2), 1);
            if (busy_len < nom - 2 || busy_len > nom + 2)
                $display("busy_len %0d nominal %0d", busy_len, nom);
        end
        @(posedge clk); #1;
        check("done_one_cycle", int'(bus_if.done), 0);
        repeat (3) @(posedge clk);
        #1;
        check("done_pulses", done_seen - dn0, 1);
        check("drop_pulses", drop_seen - d0, (drop_at > 0) ? 3 : 0);
        check("exp_bytes_left", exp_bytes.size(), 0);
        check("exp_frames_left", exp_flen.size(), 0);
        check("idle_scl", int'(bus_if.scl), 1);
        check("idle_sda", int'(bus_if.sda), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d[$];
        int f0;
        int dn0;
        int cyc;

        rst = 1'b1;
        bus_if.tvalid = 1'b0;
        bus_if.tdata = 8'h00;
        bus_if.send_bytes = 8'h00;
        bus_if.cmd1 = CMD_DATA_AUTOINC;
        bus_if.cmd2 = CMD_ADDR0;
        bus_if.cmd3 = CMD_DISP_DEFAULT;
        repeat (3) @(posedge clk);
        #1;
        check("rst_scl", int'(bus_if.scl), 1);
        check("rst_sda", int'(bus_if.sda), 1);
        check("rst_busy", int'(bus_if.busy), 0);
        check("rst_done", int'(bus_if.done), 0);
        check("rst_drop", int'(bus_if.drop), 0);
        check("rst_overflow", int'(bus_if.overflow), 0);
        rst = 1'b0;

        d = '{8'hA5};
        run_burst(d, 1, 8'h40, 8'hC0, 8'h8A, 0);

        d.delete();
        for (int i = 0; i < 14; i++) d.push_back(8'(i));
        run_burst(d, 14, 8'h40, 8'hC0, 8'h8A, 0);

        d.delete();
        for (int i = 0; i < 13; i++) d.push_back(8'($urandom));
        run_burst(d, 14, 8'h40, 8'hC0, 8'h8A, 0);

        d.delete();
        for (int i = 0; i < 20; i++) d.push_back(8'($urandom));
        run_burst(d, 14, 8'h40, 8'hC0, 8'h8A, 0);

        d.delete();
        for (int i = 0; i < 3; i++) d.push_back(8'($urandom));
        run_burst(d, 0, 8'h44, 8'hC3, 8'h8F, 0);

        d.delete();
        for (int i = 0; i < 5; i++) d.push_back(8'($urandom));
        run_burst(d, 200, 8'h40, 8'hC0, 8'h88, 0);

        d.delete();
        for (int i = 0; i < 6; i++) d.push_back(8'($urandom));
        run_burst(d, 6, 8'h40, 8'hC0, 8'h8A, 40);

        // reset while frame 1 is clocking a data bit
        d.delete();
        for (int i = 0; i < 6; i++) d.push_back(8'($urandom));
        f0  = frames_seen;
        dn0 = done_seen;
        load_burst(d, 6, 8'h40, 8'hC0, 8'h8A);
        cyc = 0;
        while (!(frames_seen == f0 + 1 && in_frame && bitq.size() >= 3 && bus_if.scl) && cyc < LIMIT) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= LIMIT) fail("reset_point_timeout");
        rst = 1'b1;
        exp_bytes.delete();
        exp_flen.delete();
        #1;
        check("midrst_scl", int'(bus_if.scl), 1);
        check("midrst_sda", int'(bus_if.sda), 1);
        check("midrst_busy", int'(bus_if.busy), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_no_done", done_seen - dn0, 0);

        d.delete();
        for (int i = 0; i < 4; i++) d.push_back(8'($urandom));
        run_burst(d, 4, 8'h40, 8'hC0, 8'h8A, 0);

        for (int t = 0; t < 6; t++) begin
            int nb;
            int sb;
            d.delete();
            nb = $urandom_range(1, 20);
            sb = $urandom_range(0, 20);
            for (int i = 0; i < nb; i++) d.push_back(8'($urandom));
            run_burst(d, sb, 8'($urandom), 8'($urandom), 8'($urandom), 0);
        end

        check("sda_change_with_scl_rise", glitch_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
